driver_trace_reader: RTL and testbench

- Bus initiator for the driver control register slave: performs the trace buffer dump sequence on the slave_addr/slave_rd/slave_wr interface and delivers the entries as a 32-bit word stream.
- For each entry, writes the trace BRAM address to register 0x200, waits for BRAM read latency, then reads eight 32-bit words from the 0x210 window (port A) or the 0x230 window (port B).
- Sits between the host DMA/stream logic and the driver control block.

---
 rtl/driver_trace_reader_pkg.sv | 23 ++
 rtl/driver_trace_reader.sv | 198 +++++++++++++++++++
 tb/tb_driver_trace_reader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/driver_trace_reader_pkg.sv
// rtl/driver_trace_reader_pkg.sv - shared driver register map, trace reader state encoding and word size
package driver_trace_reader_pkg;

  localparam int unsigned DRV_WORD_W        = 32;
  localparam logic [31:0] DRV_TRACE_ADDR_REG = 32'h0000_0200;
  localparam logic [31:0] DRV_PORT_A_BASE    = 32'h0000_0210;
  localparam logic [31:0] DRV_PORT_B_BASE    = 32'h0000_0230;

  typedef enum logic [2:0] {
    IDLE,
    SET_ADDR,
    WAIT,
    READ,
    CAPTURE,
    PUSH,
    DONE
  } drv_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/driver_trace_reader.sv
// rtl/driver_trace_reader.sv - bus initiator that dumps trace BRAM entries from the driver slave as a word stream
module driver_trace_reader
  import driver_trace_reader_pkg::*;
#(
  parameter logic [31:0] TRACE_ADDR_REG  = DRV_TRACE_ADDR_REG,
  parameter logic [31:0] PORT_A_BASE     = DRV_PORT_A_BASE,
  parameter logic [31:0] PORT_B_BASE     = DRV_PORT_B_BASE,
  parameter int unsigned WORDS_PER_ENTRY = 8,
  parameter int unsigned BRAM_WAIT       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           start_entry,
  input  logic [15:0]           num_entries,
  input  logic                  sel_port_b,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [15:0]           entries_done,
  output logic [31:0]           m_addr,
  output logic                  m_rd,
  output logic                  m_wr,
  output logic [DRV_WORD_W-1:0] m_wdata,
  input  logic [DRV_WORD_W-1:0] m_rdata,
  output logic [DRV_WORD_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_ENTRY - 1);
  localparam logic [3:0] WAIT_LOAD = (BRAM_WAIT == 0) ? 4'd0 : 4'(BRAM_WAIT - 1);

  drv_state_t            state_q, state_d;
  logic [31:0]           entry_addr_q, entry_addr_d;
  logic [15:0]           remaining_q, remaining_d;
  logic                  port_b_q, port_b_d;
  logic [3:0]            word_idx_q, word_idx_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [15:0]           entries_done_q, entries_done_d;
  logic [31:0]           m_addr_q, m_addr_d;
  logic                  m_rd_q, m_rd_d;
  logic                  m_wr_q, m_wr_d;
  logic [DRV_WORD_W-1:0] m_wdata_q, m_wdata_d;
  logic [DRV_WORD_W-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  last_word;

  assign last_word = (word_idx_q == LAST_WORD);

  always_comb begin
    state_d        = state_q;
    entry_addr_d   = entry_addr_q;
    remaining_d    = remaining_q;
    port_b_d       = port_b_q;
    word_idx_d     = word_idx_q;
    wait_cnt_d     = wait_cnt_q;
    aborted_d      = aborted_q;
    entries_done_d = entries_done_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_last_d     = out_last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          entry_addr_d   = start_entry;
          remaining_d    = num_entries;
          port_b_d       = sel_port_b;
          entries_done_d = 16'd0;
          aborted_d      = 1'b0;
          state_d        = (num_entries == 16'd0) ? DONE : SET_ADDR;
        end
      end
      SET_ADDR: begin
        word_idx_d = 4'd0;
        if (BRAM_WAIT == 0) begin
          state_d = READ;
        end else begin
          wait_cnt_d = WAIT_LOAD;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = READ;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        out_data_d  = m_rdata;
        out_valid_d = 1'b1;
        out_last_d  = last_word && (remaining_q == 16'd1);
        state_d     = PUSH;
      end
      PUSH: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (!last_word) begin
            word_idx_d = word_idx_q + 4'd1;
            state_d    = READ;
          end else begin
            entries_done_d = sat_inc16(entries_done_q);
            remaining_d    = remaining_q - 16'd1;
            if (remaining_q != 16'd1) begin
              entry_addr_d = entry_addr_q + 32'd1;
              state_d      = SET_ADDR;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything except a word already handshaken this cycle.
    if (abort && state_q != IDLE && state_q != DONE) begin
      state_d     = DONE;
      aborted_d   = 1'b1;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    busy_d    = (state_d != IDLE) && (state_d != DONE);
    done_d    = (state_d == DONE);
    m_wr_d    = (state_d == SET_ADDR);
    m_rd_d    = (state_d == READ);
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    if (m_wr_d) begin
      m_addr_d  = TRACE_ADDR_REG;
      m_wdata_d = entry_addr_d;
    end else if (m_rd_d) begin
      m_addr_d = (port_b_d ? PORT_B_BASE : PORT_A_BASE) + {26'd0, word_idx_d, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      entry_addr_q   <= 32'd0;
      remaining_q    <= 16'd0;
      port_b_q       <= 1'b0;
      word_idx_q     <= 4'd0;
      wait_cnt_q     <= 4'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
      entries_done_q <= 16'd0;
      m_addr_q       <= 32'd0;
      m_rd_q         <= 1'b0;
      m_wr_q         <= 1'b0;
      m_wdata_q      <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      entry_addr_q   <= entry_addr_d;
      remaining_q    <= remaining_d;
      port_b_q       <= port_b_d;
      word_idx_q     <= word_idx_d;
      wait_cnt_q     <= wait_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
      entries_done_q <= entries_done_d;
      m_addr_q       <= m_addr_d;
      m_rd_q         <= m_rd_d;
      m_wr_q         <= m_wr_d;
      m_wdata_q      <= m_wdata_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign entries_done = entries_done_q;
  assign m_addr       = m_addr_q;
  assign m_rd         = m_rd_q;
  assign m_wr         = m_wr_q;
  assign m_wdata      = m_wdata_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;

endmodule

// File: tb/tb_driver_trace_reader.sv
// tb/tb_driver_trace_reader.sv - directed bench for driver_trace_reader with a transaction-level model
module tb_driver_trace_reader;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_op_t;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_entry = 32'd0;
  logic [15:0] num_entries = 16'd0;
  logic        sel_port_b = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, aborted;
  logic [15:0] entries_done;
  logic [31:0] m_addr;
  logic        m_rd, m_wr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;

  always #5 clk = ~clk;

  driver_trace_reader #(.BRAM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .start_entry(start_entry),
    .num_entries(num_entries), .sel_port_b(sel_port_b), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .entries_done(entries_done),
    .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  // Slave returns the read address as data one cycle after the strobe.
  always @(posedge clk) if (m_rd) m_rdata <= m_addr;

  bus_op_t     exp_bus[$];
  word_t       exp_word[$];
  bus_op_t     op;
  word_t       wd;
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  bit          mon_en = 1'b0;
  int          hs_cnt, bus_cnt, wr_cyc, done_cyc, abort_cyc, start_cyc;
  bit          first_rd_pending, done_seen, prev_stall, prev_done;
  logic [31:0] prev_data;
  logic [15:0] exp_ed;
  bit          exp_ab;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_wr || m_rd) begin
        check("strobe_exclusive", 32'(m_rd & m_wr), 32'd0);
        if (done_seen || (abort_cyc >= 0 && cyc > abort_cyc)) check("bus_after_end", 32'd1, 32'd0);
        else if (exp_bus.size() == 0) check("bus_extra", 32'd1, 32'd0);
        else begin
          op = exp_bus.pop_front();
          bus_cnt++;
          check("bus_kind_wr", 32'(m_wr), 32'(op.wr));
          check("bus_addr", m_addr, op.addr);
          if (op.wr) begin
            check("wr_data", m_wdata, op.data);
            wr_cyc = cyc;
            first_rd_pending = 1'b1;
          end else begin
            check("rd_while_valid", 32'(out_valid), 32'd0);
            if (first_rd_pending) begin
              check("bram_wait_gap", 32'(cyc - wr_cyc), 32'd3);
              first_rd_pending = 1'b0;
            end
          end
        end
      end
      if (prev_stall && !(abort_cyc >= 0 && cyc == abort_cyc + 1)) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_word.size() == 0) check("word_extra", 32'd1, 32'd0);
        else begin
          wd = exp_word.pop_front();
          check("word_data", out_data, wd.data);
          check("word_last", 32'(out_last), 32'(wd.last));
          hs_cnt++;
        end
      end
      if (abort) abort_cyc = cyc;
      if (done) begin
        check("done_one_cycle", 32'(prev_done), 32'd0);
        check("busy_in_done", 32'(busy), 32'd0);
        check("entries_done", 32'(entries_done), 32'(exp_ed));
        check("aborted_flag", 32'(aborted), 32'(exp_ab));
        done_seen = 1'b1;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_done  = done;
    end
  end

  task automatic build_model(input logic [31:0] s, input int n, input bit pb);
    logic [31:0] base;
    base = pb ? 32'h230 : 32'h210;
    exp_bus.delete();
    exp_word.delete();
    for (int e = 0; e < n; e++) begin
      exp_bus.push_back('{wr: 1'b1, addr: 32'h200, data: s + 32'(e)});
      for (int w = 0; w < 8; w++) begin
        exp_bus.push_back('{wr: 1'b0, addr: base + 32'(4 * w), data: 32'h0});
        exp_word.push_back('{data: base + 32'(4 * w), last: (e == n - 1 && w == 7)});
      end
    end
  endtask

  task automatic run_job(input logic [31:0] s, input int n, input bit pb,
                         input int stall_idx, input int stall_len, input int abort_idx,
                         input bit poke_start, input logic [15:0] ed, input bit ab,
                         input int exp_hs, input int exp_ops, input int exp_lat);
    int stall_left;
    bit aborted_once;
    hs_cnt = 0; bus_cnt = 0; done_seen = 0; first_rd_pending = 0; abort_cyc = -1;
    prev_stall = 0; prev_done = 0; done_cyc = -1; exp_ed = ed; exp_ab = ab; mon_en = 1'b1;
    stall_left = stall_len;
    aborted_once = 1'b0;
    start_entry = s; num_entries = 16'(n); sel_port_b = pb; out_ready = 1'b1; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(n != 0));
    for (int c = 0; c < 400 && !done_seen; c++) begin
      start = poke_start && (c == 3);
      if (start) begin
        num_entries = 16'd0;
        sel_port_b  = !pb;
      end
      abort = 1'b0;
      out_ready = 1'b1;
      if (out_valid && hs_cnt == stall_idx && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      if (out_valid && hs_cnt == abort_idx && !aborted_once) begin
        out_ready = 1'b0;
        abort = 1'b1;
        aborted_once = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    check("handshake_count", 32'(hs_cnt), 32'(exp_hs));
    check("bus_op_count", 32'(bus_cnt), 32'(exp_ops));
    check("done_latency", 32'(done_cyc - start_cyc), 32'(exp_lat));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_aborted"}, 32'(aborted), 32'd0);
    check({tag, "_entries_done"}, 32'(entries_done), 32'd0);
    check({tag, "_m_addr"}, m_addr, 32'd0);
    check({tag, "_strobes"}, 32'({m_rd, m_wr}), 32'd0);
    check({tag, "_m_wdata"}, m_wdata, 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_flags"}, 32'({out_valid, out_last}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Single entry, port B: 1 + 2 + 8*3 cycles to DONE.
    build_model(32'h40, 1, 1'b1);
    check("model_pin_wr", exp_bus[0].data, 32'h40);
    check("model_pin_last_data", exp_word[7].data, 32'h24C);
    check("model_pin_last_flag", 32'(exp_word[7].last), 32'd1);
    run_job(32'h40, 1, 1'b1, -1, 0, -1, 1'b0, 16'd1, 1'b0, 8, 9, 28);

    // Two entries across the 32-bit wrap, port A.
    build_model(32'hFFFF_FFFF, 2, 1'b0);
    check("model_pin_wrap", exp_bus[9].data, 32'h0);
    check("model_pin_mid_last", 32'(exp_word[7].last), 32'd0);
    run_job(32'hFFFF_FFFF, 2, 1'b0, -1, 0, -1, 1'b0, 16'd2, 1'b0, 16, 18, 55);

    // Backpressure: ready low for 5 cycles on the third word.
    build_model(32'h1234, 1, 1'b0);
    run_job(32'h1234, 1, 1'b0, 2, 5, -1, 1'b0, 16'd1, 1'b0, 8, 9, 33);

    // Abort during PUSH of word 5 of entry 2, with a start poked while busy.
    build_model(32'h10, 3, 1'b1);
    run_job(32'h10, 3, 1'b1, -1, 0, 12, 1'b1, 16'd1, 1'b1, 12, 15, 46);
    check("aborted_holds", 32'(aborted), 32'd1);
    check("entries_done_holds", 32'(entries_done), 32'd1);

    // Zero length: no bus activity, done in the cycle after start is accepted.
    build_model(32'h55, 0, 1'b0);
    run_job(32'h55, 0, 1'b0, -1, 0, -1, 1'b0, 16'd0, 1'b0, 0, 0, 1);

    // Reset while in READ.
    mon_en = 1'b0;
    start_entry = 32'h7; num_entries = 16'd1; sel_port_b = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && !m_rd; c++) begin
      @(posedge clk); #1;
    end
    check("reached_read", 32'(m_rd), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    check("midreset_no_done", 32'({done, busy}), 32'd0);

    build_model(32'h100, 1, 1'b0);
    run_job(32'h100, 1, 1'b0, -1, 0, -1, 1'b0, 16'd1, 1'b0, 8, 9, 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
